// File: rtl/tima_reload_unit.sv
// tima_reload_unit: 8-bit DMG-style timer counter with delayed modulo reload and interrupt pulse.
// Ports:
//   clk_i        system clock, rising edge
//   nreset_i     synchronous active-low reset
//   tick_i       one-cycle increment strobe from the divider select mux
//   wr_tima_i    CPU write strobe for TIMA
//   wr_tma_i     CPU write strobe for TMA
//   wr_data_i    CPU write data
//   tima_o       current counter value
//   tma_o        current modulo register
//   reloading_o  high while a reload is pending (OVF)
//   irq_o        one-cycle timer interrupt request
module tima_reload_unit #(
    parameter int         RELOAD_DELAY = 4,
    parameter logic [7:0] INITIAL_TIMA = 8'h00
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       tick_i,
    input  logic       wr_tima_i,
    input  logic       wr_tma_i,
    input  logic [7:0] wr_data_i,
    output logic [7:0] tima_o,
    output logic [7:0] tma_o,
    output logic       reloading_o,
    output logic       irq_o
);
    typedef enum logic [1:0] {RUN, OVF, RELOAD} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tima_q, tima_d, tma_q, tma_d;
    logic       irq_q, irq_d, reloading_q, reloading_d;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tima_d      = tima_q;
        irq_d       = 1'b0;
        tma_d       = wr_tma_i ? wr_data_i : tma_q;
        case (state_q)
            RUN: begin
                if (wr_tima_i) begin
                    tima_d = wr_data_i;
                end else if (tick_i) begin
                    tima_d = tima_q + 8'd1;
                    if (tima_q == 8'hFF) begin
                        state_d = OVF;
                        cnt_d   = 4'(RELOAD_DELAY - 1);
                    end
                end
            end
            OVF: begin
                if (wr_tima_i) begin
                    // A TIMA write during the pending window cancels the reload and irq.
                    tima_d  = wr_data_i;
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    // A TMA write on the reload edge passes straight through to TIMA.
                    tima_d  = wr_tma_i ? wr_data_i : tma_q;
                    state_d = RELOAD;
                    irq_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELOAD: begin
                // TIMA writes and ticks are dropped; TMA writes still reach TIMA.
                state_d = RUN;
                tima_d  = wr_tma_i ? wr_data_i : tima_q;
            end
            default: state_d = RUN;
        endcase
        reloading_d = (state_d == OVF);
    end
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            tima_q      <= INITIAL_TIMA;
            tma_q       <= 8'h00;
            irq_q       <= 1'b0;
            reloading_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tima_q      <= tima_d;
            tma_q       <= tma_d;
            irq_q       <= irq_d;
            reloading_q <= reloading_d;
        end
    end
    assign tima_o      = tima_q;
    assign tma_o       = tma_q;
    assign reloading_o = reloading_q;
    assign irq_o       = irq_q;
endmodule
